// File: rtl/id_stage.sv
// RV32I decode stage: 2-entry skid buffer holding pre-decoded immediate fields.
// Define ID_STAGE_ILLEGAL_DETECT_EN to flag unrecognised opcodes on out_illegal.
module id_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [2:0]      out_imm_sel,
  output logic [20:0]     out_imm,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic [2:0]      sel;
    logic [20:0]     imm;
    logic            ill;
  } entry_t;

  function automatic entry_t decode(input logic [PC_W-1:0] pc, input logic [31:0] inst);
    entry_t e;
    e      = '0;
    e.pc   = pc;
    e.inst = inst;
    e.sel  = 3'b111;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        e.sel       = 3'b000;
        e.imm[11:0] = inst[31:20];
      end
      7'b0100011: begin
        e.sel       = 3'b000;
        e.imm[11:0] = {inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        e.sel       = 3'b001;
        e.imm[11:0] = {inst[31], inst[7], inst[30:25], inst[11:8]};
      end
      7'b1101111: begin
        e.sel = 3'b010;
        e.imm = {inst[31], inst[31], inst[19:12], inst[20], inst[30:21]};
      end
      7'b0110111, 7'b0010111: begin
        e.sel       = 3'b011;
        e.imm[19:0] = inst[31:12];
      end
      7'b0110011: e.sel = 3'b111;
      default: begin
`ifdef ID_STAGE_ILLEGAL_DETECT_EN
        e.ill = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  state_t state_q, state_n;
  entry_t slot0, slot1, in_dec;
  logic   in_ready_q;
  logic   push, pop;
  logic   ld0_new, ld0_shift, ld1_new;

  assign in_dec    = decode(in_pc, in_inst);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_n;
  end

  // slot0 is always the head; slot1 only ever holds the younger beat in FULL
  always_comb begin
    state_n   = state_q;
    ld0_new   = 1'b0;
    ld0_shift = 1'b0;
    ld1_new   = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_n = BUSY;
          ld0_new = 1'b1;
        end
        BUSY: begin
          if (push && pop) begin
            ld0_new = 1'b1;
          end else if (push) begin
            state_n = FULL;
            ld1_new = 1'b1;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_n   = BUSY;
          ld0_shift = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // in_ready is registered separately so it stays low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready_q <= 1'b0;
    else        in_ready_q <= (state_n != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (ld0_new)        slot0 <= in_dec;
      else if (ld0_shift) slot0 <= slot1;
      if (ld1_new)        slot1 <= in_dec;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_pc      = slot0.pc;
  assign out_inst    = slot0.inst;
  assign out_imm_sel = slot0.sel;
  assign out_imm     = slot0.imm;
  assign out_illegal = slot0.ill;

endmodule
